dff_pipe: RTL and testbench

//  Parametrised register pipeline: next generation of the 8-bit sync-reset DFF.
//  - Carries WIDTH-bit data through DEPTH stages, each with a valid bit.
//  - Supports stall (enable), flush and a programmable reset value.
//  - Reports stage occupancy.
//  - Used for fixed-latency alignment of datapaths, e.g. matching a multiplier's latency.

---
 rtl/dff_pipe_if.sv | 26 ++
 rtl/dff_pipe.sv | 77 +++++++
 tb/tb_dff_pipe.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/dff_pipe_if.sv
// dff_pipe_if: stream bundle for dff_pipe (stall, flush, data in/out, occupancy).
// master drives the input side, slave is the pipeline itself.
interface dff_pipe_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             en;
  logic             flush;
  logic [WIDTH-1:0] d;
  logic             d_valid;
  logic [WIDTH-1:0] q;
  logic             q_valid;
  logic [CNT_W-1:0] count;

  modport master (
    output en, flush, d, d_valid,
    input  q, q_valid, count
  );

  modport slave (
    input  en, flush, d, d_valid,
    output q, q_valid, count
  );
endinterface

// File: rtl/dff_pipe.sv
// dff_pipe: DEPTH-stage WIDTH-bit register pipeline with valid, stall, flush.
// Optional macro DFF_PIPE_GATE_EN: data stages load only when a valid shifts in.
module dff_pipe #(
  parameter int               WIDTH   = 8,
  parameter int               DEPTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input logic       clk,
  input logic       reset,
  dff_pipe_if.slave p
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][WIDTH-1:0] data;
  logic [DEPTH-1:0][WIDTH-1:0] data_in;
  logic [DEPTH-1:0]            vld;
  logic [DEPTH-1:0]            vld_in;
  logic [CNT_W-1:0]            cnt;
  logic [CNT_W-1:0]            cnt_nxt;

  // stage inputs: stage 0 takes d, stage i takes stage i-1
  always_comb begin
    data_in    = '0;
    vld_in     = '0;
    data_in[0] = p.d;
    vld_in[0]  = p.d_valid;
    for (int i = 1; i < DEPTH; i++) begin
      data_in[i] = data[i-1];
      vld_in[i]  = vld[i-1];
    end
  end

  // occupancy moves only when one valid enters and none leaves, or vice versa
  always_comb begin
    cnt_nxt = cnt;
    if (p.d_valid && !vld[DEPTH-1])
      cnt_nxt = cnt + CNT_W'(1);
    else if (!p.d_valid && vld[DEPTH-1])
      cnt_nxt = cnt - CNT_W'(1);
  end

  // valid bits and count: reset over flush over advance
  always_ff @(posedge clk) begin
    priority case (1'b1)
      reset, p.flush: begin
        vld <= '0;
        cnt <= '0;
      end
      p.en: begin
        vld <= vld_in;
        cnt <= cnt_nxt;
      end
      default: ;
    endcase
  end

  // data stages: bubbles either carry d along or leave the stage untouched
  always_ff @(posedge clk) begin
    priority case (1'b1)
      reset, p.flush: data <= {DEPTH{RST_VAL}};
      p.en: begin
`ifdef DFF_PIPE_GATE_EN
        for (int i = 0; i < DEPTH; i++)
          if (vld_in[i])
            data[i] <= data_in[i];
`else
        data <= data_in;
`endif
      end
      default: ;
    endcase
  end

  assign p.q       = data[DEPTH-1];
  assign p.q_valid = vld[DEPTH-1];
  assign p.count   = cnt;
endmodule

// File: tb/tb_dff_pipe.sv
// tb_dff_pipe: directed checks of dff_pipe in three configurations.
// Expected values are hand-derived from the pipeline's cycle behaviour.
module tb_dff_pipe;
  logic clk = 1'b0;
  logic rst0, rst1, rst2;
  int   checks = 0;
  int   fails  = 0;

  always #5 clk = ~clk;

  dff_pipe_if #(.WIDTH(8), .DEPTH(4)) i0 ();
  dff_pipe_if #(.WIDTH(8), .DEPTH(4)) i1 ();
  dff_pipe_if #(.WIDTH(1), .DEPTH(1)) i2 ();

  dff_pipe #(.WIDTH(8), .DEPTH(4)) u0 (
    .clk(clk), .reset(rst0), .p(i0.slave));
  dff_pipe #(.WIDTH(8), .DEPTH(4), .RST_VAL(8'h3C)) u1 (
    .clk(clk), .reset(rst1), .p(i1.slave));
  dff_pipe #(.WIDTH(1), .DEPTH(1)) u2 (
    .clk(clk), .reset(rst2), .p(i2.slave));

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // advance one edge; outputs are sampled 1ns after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv0(input logic en, input logic fl,
                      input logic v, input logic [7:0] d);
    i0.en = en; i0.flush = fl; i0.d_valid = v; i0.d = d;
  endtask

  task automatic drv1(input logic en, input logic fl,
                      input logic v, input logic [7:0] d);
    i1.en = en; i1.flush = fl; i1.d_valid = v; i1.d = d;
  endtask

  initial begin
    logic [7:0] eq;
    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
    drv0(1'b0, 1'b0, 1'b0, 8'h00);
    drv1(1'b0, 1'b0, 1'b0, 8'h00);
    i2.en = 1'b0; i2.flush = 1'b0; i2.d_valid = 1'b0; i2.d = 1'b0;
    #1;
    step();
    step();
    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;

    // 1: reset state, single item latency
    chk("rst_q", i0.q, 8'h00);
    chk("rst_qv", i0.q_valid, 1'b0);
    chk("rst_cnt", i0.count, 0);
    chk("rst1_q", i1.q, 8'h3C);
    drv0(1'b1, 1'b0, 1'b1, 8'hA5);
    step();
    chk("t1_cnt1", i0.count, 1);
    drv0(1'b1, 1'b0, 1'b0, 8'h00);
    step();
    step();
    chk("t1_qv_e3", i0.q_valid, 1'b0);
    step();
    chk("t1_q_e4", i0.q, 8'hA5);
    chk("t1_qv_e4", i0.q_valid, 1'b1);
    chk("t1_cnt_e4", i0.count, 1);
    step();
    chk("t1_qv_e5", i0.q_valid, 1'b0);
    chk("t1_cnt_e5", i0.count, 0);

    // 2: stream with a 3-cycle stall
    for (int k = 1; k <= 6; k++) begin
      drv0(1'b1, 1'b0, 1'b1, 8'(k));
      step();
      chk("t2_cnt", i0.count, (k < 4) ? k : 4);
      if (k >= 4) chk("t2_q", i0.q, k - 3);
    end
    for (int k = 0; k < 3; k++) begin
      drv0(1'b0, 1'b0, 1'b1, 8'h99);
      step();
      chk("t2_stall_q", i0.q, 8'd3);
      chk("t2_stall_qv", i0.q_valid, 1'b1);
      chk("t2_stall_cnt", i0.count, 4);
    end
    for (int j = 1; j <= 4; j++) begin
      drv0(1'b1, 1'b0, 1'b1, 8'(6 + j));
      step();
      chk("t2_resume_q", i0.q, 3 + j);
      chk("t2_resume_cnt", i0.count, 4);
    end

    // 3: flush while full, with a valid input in the same cycle
    drv0(1'b1, 1'b1, 1'b1, 8'hEE);
    step();
    chk("t3_q", i0.q, 8'h00);
    chk("t3_qv", i0.q_valid, 1'b0);
    chk("t3_cnt", i0.count, 0);
    for (int k = 0; k < 4; k++) begin
      drv0(1'b1, 1'b0, 1'b0, 8'h00);
      step();
      chk("t3_drain_qv", i0.q_valid, 1'b0);
      chk("t3_drain_cnt", i0.count, 0);
    end

    // 4: reset mid-stream beats flush and en
    for (int k = 0; k < 3; k++) begin
      drv1(1'b1, 1'b0, 1'b1, 8'(8'h10 + k));
      step();
    end
    chk("t4_cnt_pre", i1.count, 3);
    rst1 = 1'b1;
    drv1(1'b1, 1'b1, 1'b1, 8'h55);
    step();
    rst1 = 1'b0;
    chk("t4_q", i1.q, 8'h3C);
    chk("t4_qv", i1.q_valid, 1'b0);
    chk("t4_cnt", i1.count, 0);
    for (int k = 0; k < 4; k++) begin
      drv1(1'b1, 1'b0, 1'b0, 8'h00);
      step();
      chk("t4_drain_qv", i1.q_valid, 1'b0);
    end

    // 5: alternating valid/bubble, bubble data 8'hFF
    for (int k = 1; k <= 9; k++) begin
      if (k % 2 == 1) drv0(1'b1, 1'b0, 1'b1, 8'h11);
      else            drv0(1'b1, 1'b0, 1'b0, 8'hFF);
      step();
      if (k >= 4) begin
`ifdef DFF_PIPE_GATE_EN
        eq = 8'h11;
`else
        eq = ((k - 3) % 2 == 1) ? 8'h11 : 8'hFF;
`endif
        chk("t5_q", i0.q, eq);
        chk("t5_qv", i0.q_valid, ((k - 3) % 2 == 1) ? 1'b1 : 1'b0);
        chk("t5_cnt", i0.count, 2);
      end
    end

    // 6: DEPTH=1, WIDTH=1
    chk("t6_rst_qv", i2.q_valid, 1'b0);
    chk("t6_rst_cnt", i2.count, 0);
    i2.en = 1'b1; i2.d_valid = 1'b1; i2.d = 1'b1;
    step();
    chk("t6_q", i2.q, 1'b1);
    chk("t6_qv", i2.q_valid, 1'b1);
    chk("t6_cnt", i2.count, 1);
    i2.en = 1'b0; i2.d_valid = 1'b0; i2.d = 1'b0;
    step();
    chk("t6_hold_qv", i2.q_valid, 1'b1);
    chk("t6_hold_cnt", i2.count, 1);
    i2.en = 1'b1;
    step();
    chk("t6_out_qv", i2.q_valid, 1'b0);
    chk("t6_out_cnt", i2.count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
